// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decode to ALU opcode, operand forwarding, load-use hazard, stall/flush.
// Optional feature macro: RV_FORWARDING_EN (undefined = no forwarding, wider RAW interlock).
module id_ex_stage (
    input  logic        clk,
    input  logic        resetN,
    input  logic        inValid,
    input  logic [31:0] inPc,
    input  logic [31:0] inRs1Data,
    input  logic [31:0] inRs2Data,
    input  logic [31:0] inImm,
    input  logic [4:0]  inRs1,
    input  logic [4:0]  inRs2,
    input  logic [4:0]  inRd,
    input  logic [6:0]  inOpcode,
    input  logic [2:0]  inFunct3,
    input  logic [6:0]  inFunct7,
    input  logic        stall,
    input  logic        flush,
    input  logic        exMemRegWrite,
    input  logic        memWbRegWrite,
    input  logic [4:0]  exMemRd,
    input  logic [4:0]  memWbRd,
    input  logic [31:0] exMemResult,
    input  logic [31:0] memWbResult,
    output logic [31:0] operand1,
    output logic [31:0] operand2,
    output logic [2:0]  aluOp,
    output logic        outValid,
    output logic        outRegWrite,
    output logic        outMemRead,
    output logic        outMemWrite,
    output logic        outBranch,
    output logic        outBranchNe,
    output logic [4:0]  outRd,
    output logic [31:0] outPc,
    output logic [31:0] outStoreData,
    output logic        hazardStall,
    output logic        illegalInstr
);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_MUL = 3'b100,
        ALU_SLL = 3'b101
    } alu_op_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        branch_ne;
        logic        illegal;
        logic        use_imm;
        alu_op_e     alu_op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
    } stage_t;

    stage_t  stage_d, stage_q;
    alu_op_e dec_op;
    logic    dec_legal, dec_writes, dec_use_imm, dec_use_rs2;
    logic    dec_mem_read, dec_mem_write, dec_branch, dec_branch_ne;
    logic    load_use;
    logic [31:0] fwd_rs1, fwd_rs2;

    function automatic logic raw_hit(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic use_rs2);
        return (rd != 5'd0) && ((rd == rs1) || (use_rs2 && (rd == rs2)));
    endfunction

    always_comb begin
        dec_op        = ALU_ADD;
        dec_legal     = 1'b0;
        dec_writes    = 1'b0;
        dec_use_imm   = 1'b0;
        dec_use_rs2   = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_branch    = 1'b0;
        dec_branch_ne = 1'b0;
        case (inOpcode)
            OP_R: begin
                dec_writes  = 1'b1;
                dec_use_rs2 = 1'b1;
                case ({inFunct7, inFunct3})
                    {7'b0000000, 3'b000}: begin dec_op = ALU_ADD; dec_legal = 1'b1; end
                    {7'b0100000, 3'b000}: begin dec_op = ALU_SUB; dec_legal = 1'b1; end
                    {7'b0000001, 3'b000}: begin dec_op = ALU_MUL; dec_legal = 1'b1; end
                    {7'b0000000, 3'b111}: begin dec_op = ALU_AND; dec_legal = 1'b1; end
                    {7'b0000000, 3'b110}: begin dec_op = ALU_OR;  dec_legal = 1'b1; end
                    {7'b0000000, 3'b001}: begin dec_op = ALU_SLL; dec_legal = 1'b1; end
                    default: ;
                endcase
            end
            OP_IMM: begin
                dec_writes  = 1'b1;
                dec_use_imm = 1'b1;
                case (inFunct3)
                    3'b000: begin dec_op = ALU_ADD; dec_legal = 1'b1; end
                    3'b111: begin dec_op = ALU_AND; dec_legal = 1'b1; end
                    3'b110: begin dec_op = ALU_OR;  dec_legal = 1'b1; end
                    3'b001: begin dec_op = ALU_SLL; dec_legal = (inFunct7 == 7'b0000000); end
                    default: ;
                endcase
            end
            OP_LOAD: begin
                dec_writes   = 1'b1;
                dec_use_imm  = 1'b1;
                dec_mem_read = 1'b1;
                dec_legal    = 1'b1;
            end
            OP_STORE: begin
                dec_use_imm   = 1'b1;
                dec_use_rs2   = 1'b1;
                dec_mem_write = 1'b1;
                dec_legal     = 1'b1;
            end
            OP_BRANCH: begin
                dec_use_rs2   = 1'b1;
                dec_branch    = 1'b1;
                dec_op        = ALU_SUB;
                dec_branch_ne = (inFunct3 == 3'b001);
                dec_legal     = (inFunct3 == 3'b000) || (inFunct3 == 3'b001);
            end
            default: ;
        endcase
    end

    assign load_use = inValid && stage_q.valid && stage_q.mem_read
                      && raw_hit(stage_q.rd, inRs1, inRs2, dec_use_rs2);

`ifdef RV_FORWARDING_EN
    assign hazardStall = !flush && load_use;
`else
    // Without bypass paths, any producer still in EX or EX/MEM must drain first.
    assign hazardStall = !flush && (load_use
        || (inValid && stage_q.valid && stage_q.reg_write
            && raw_hit(stage_q.rd, inRs1, inRs2, dec_use_rs2))
        || (inValid && exMemRegWrite && raw_hit(exMemRd, inRs1, inRs2, dec_use_rs2)));
`endif

    always_comb begin
        stage_d = stage_q;
        if (flush || (!stall && hazardStall)) begin
            stage_d = '0;
        end else if (!stall) begin
            stage_d = '0;
            if (inValid && !dec_legal) begin
                stage_d.illegal = 1'b1;
            end else if (inValid) begin
                stage_d.valid     = 1'b1;
                stage_d.reg_write = dec_writes && (inRd != 5'd0);
                stage_d.mem_read  = dec_mem_read;
                stage_d.mem_write = dec_mem_write;
                stage_d.branch    = dec_branch;
                stage_d.branch_ne = dec_branch_ne;
                stage_d.use_imm   = dec_use_imm;
                stage_d.alu_op    = dec_op;
                stage_d.rd        = inRd;
                stage_d.rs1       = inRs1;
                stage_d.rs2       = inRs2;
                stage_d.pc        = inPc;
                stage_d.rs1_data  = inRs1Data;
                stage_d.rs2_data  = inRs2Data;
                stage_d.imm       = inImm;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) stage_q <= '0;
        else         stage_q <= stage_d;
    end

`ifdef RV_FORWARDING_EN
    always_comb begin
        fwd_rs1 = stage_q.rs1_data;
        if (stage_q.rs1 != 5'd0 && exMemRegWrite && exMemRd == stage_q.rs1)
            fwd_rs1 = exMemResult;
        else if (stage_q.rs1 != 5'd0 && memWbRegWrite && memWbRd == stage_q.rs1)
            fwd_rs1 = memWbResult;
        fwd_rs2 = stage_q.rs2_data;
        if (stage_q.rs2 != 5'd0 && exMemRegWrite && exMemRd == stage_q.rs2)
            fwd_rs2 = exMemResult;
        else if (stage_q.rs2 != 5'd0 && memWbRegWrite && memWbRd == stage_q.rs2)
            fwd_rs2 = memWbResult;
    end
`else
    logic unused_fwd;
    assign fwd_rs1    = stage_q.rs1_data;
    assign fwd_rs2    = stage_q.rs2_data;
    assign unused_fwd = ^{memWbRegWrite, memWbRd, exMemResult, memWbResult,
                          stage_q.rs1, stage_q.rs2};
`endif

    assign operand1     = fwd_rs1;
    assign operand2     = stage_q.use_imm ? stage_q.imm : fwd_rs2;
    assign outStoreData = fwd_rs2;
    assign aluOp        = stage_q.alu_op;
    assign outValid     = stage_q.valid;
    assign outRegWrite  = stage_q.reg_write;
    assign outMemRead   = stage_q.mem_read;
    assign outMemWrite  = stage_q.mem_write;
    assign outBranch    = stage_q.branch;
    assign outBranchNe  = stage_q.branch_ne;
    assign outRd        = stage_q.rd;
    assign outPc        = stage_q.pc;
    assign illegalInstr = stage_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; expectations follow RV_FORWARDING_EN when it is defined.
module tb_id_ex_stage;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic        clk = 1'b0;
    logic        resetN, inValid, stall, flush;
    logic [31:0] inPc, inRs1Data, inRs2Data, inImm;
    logic [4:0]  inRs1, inRs2, inRd;
    logic [6:0]  inOpcode, inFunct7;
    logic [2:0]  inFunct3;
    logic        exMemRegWrite, memWbRegWrite;
    logic [4:0]  exMemRd, memWbRd;
    logic [31:0] exMemResult, memWbResult;
    logic [31:0] operand1, operand2, outPc, outStoreData;
    logic [2:0]  aluOp;
    logic        outValid, outRegWrite, outMemRead, outMemWrite, outBranch, outBranchNe;
    logic [4:0]  outRd;
    logic        hazardStall, illegalInstr;

    int tests = 0;
    int fails = 0;

    id_ex_stage dut (
        .clk(clk), .resetN(resetN), .inValid(inValid), .inPc(inPc),
        .inRs1Data(inRs1Data), .inRs2Data(inRs2Data), .inImm(inImm),
        .inRs1(inRs1), .inRs2(inRs2), .inRd(inRd), .inOpcode(inOpcode),
        .inFunct3(inFunct3), .inFunct7(inFunct7), .stall(stall), .flush(flush),
        .exMemRegWrite(exMemRegWrite), .memWbRegWrite(memWbRegWrite),
        .exMemRd(exMemRd), .memWbRd(memWbRd), .exMemResult(exMemResult),
        .memWbResult(memWbResult), .operand1(operand1), .operand2(operand2),
        .aluOp(aluOp), .outValid(outValid), .outRegWrite(outRegWrite),
        .outMemRead(outMemRead), .outMemWrite(outMemWrite), .outBranch(outBranch),
        .outBranchNe(outBranchNe), .outRd(outRd), .outPc(outPc),
        .outStoreData(outStoreData), .hazardStall(hazardStall), .illegalInstr(illegalInstr)
    );

    always #5 clk = ~clk;

    // ctl = {valid, regWrite, memRead, memWrite, branch, branchNe, illegal}
    typedef struct {
        logic        v;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic [2:0]  e_op;
        logic [31:0] e_op1, e_op2, e_sd;
        logic [6:0]  e_ctl;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
        inValid = 1'b1; inOpcode = opc; inFunct3 = f3; inFunct7 = f7;
        inRs1 = rs1; inRs2 = rs2; inRd = rd;
        inRs1Data = d1; inRs2Data = d2; inImm = imm;
    endtask

    task automatic clear_fwd();
        exMemRegWrite = 1'b0; memWbRegWrite = 1'b0;
        exMemRd = 5'd0; memWbRd = 5'd0; exMemResult = '0; memWbResult = '0;
    endtask

    function automatic logic [6:0] ctl();
        return {outValid, outRegWrite, outMemRead, outMemWrite, outBranch, outBranchNe, illegalInstr};
    endfunction

    initial begin
        vecs[0]  = '{1'b1, OP_R,      3'b000, 7'h20, 5'd1, 5'd2, 5'd5, 32'd10, 32'd3, 32'd0,  3'b001, 32'd10, 32'd3,  32'd3, 7'b1100000};
        vecs[1]  = '{1'b1, OP_R,      3'b000, 7'h01, 5'd1, 5'd2, 5'd6, 32'd10, 32'd3, 32'd0,  3'b100, 32'd10, 32'd3,  32'd3, 7'b1100000};
        vecs[2]  = '{1'b1, OP_R,      3'b001, 7'h00, 5'd1, 5'd2, 5'd7, 32'd10, 32'd3, 32'd0,  3'b101, 32'd10, 32'd3,  32'd3, 7'b1100000};
        vecs[3]  = '{1'b1, OP_R,      3'b000, 7'h00, 5'd1, 5'd2, 5'd8, 32'd10, 32'd3, 32'd0,  3'b000, 32'd10, 32'd3,  32'd3, 7'b1100000};
        vecs[4]  = '{1'b1, OP_R,      3'b111, 7'h00, 5'd1, 5'd2, 5'd5, 32'd10, 32'd3, 32'd0,  3'b010, 32'd10, 32'd3,  32'd3, 7'b1100000};
        vecs[5]  = '{1'b1, OP_R,      3'b110, 7'h00, 5'd1, 5'd2, 5'd6, 32'd10, 32'd3, 32'd0,  3'b011, 32'd10, 32'd3,  32'd3, 7'b1100000};
        vecs[6]  = '{1'b1, OP_IMM,    3'b000, 7'h00, 5'd0, 5'd2, 5'd5, 32'd0,  32'd3, 32'hFFFFFFFC, 3'b000, 32'd0, 32'hFFFFFFFC, 32'd3, 7'b1100000};
        vecs[7]  = '{1'b1, OP_IMM,    3'b000, 7'h00, 5'd0, 5'd2, 5'd0, 32'd0,  32'd3, 32'hFFFFFFFC, 3'b000, 32'd0, 32'hFFFFFFFC, 32'd3, 7'b1000000};
        vecs[8]  = '{1'b1, OP_IMM,    3'b111, 7'h00, 5'd1, 5'd2, 5'd7, 32'd10, 32'd3, 32'hF0, 3'b010, 32'd10, 32'hF0, 32'd3, 7'b1100000};
        vecs[9]  = '{1'b1, OP_IMM,    3'b001, 7'h00, 5'd1, 5'd2, 5'd8, 32'd10, 32'd3, 32'd4,  3'b101, 32'd10, 32'd4,  32'd3, 7'b1100000};
        vecs[10] = '{1'b1, OP_LOAD,   3'b010, 7'h00, 5'd1, 5'd2, 5'd9, 32'd10, 32'd3, 32'd8,  3'b000, 32'd10, 32'd8,  32'd3, 7'b1110000};
        vecs[11] = '{1'b1, OP_STORE,  3'b010, 7'h00, 5'd1, 5'd2, 5'd0, 32'd10, 32'd3, 32'd12, 3'b000, 32'd10, 32'd12, 32'd3, 7'b1001000};
        vecs[12] = '{1'b1, OP_BRANCH, 3'b000, 7'h00, 5'd1, 5'd2, 5'd0, 32'd10, 32'd3, 32'd16, 3'b001, 32'd10, 32'd3,  32'd3, 7'b1000100};
        vecs[13] = '{1'b1, OP_BRANCH, 3'b001, 7'h00, 5'd1, 5'd2, 5'd0, 32'd10, 32'd3, 32'd16, 3'b001, 32'd10, 32'd3,  32'd3, 7'b1000110};
        vecs[14] = '{1'b1, 7'h7F,     3'b000, 7'h00, 5'd1, 5'd2, 5'd5, 32'd10, 32'd3, 32'd0,  3'b000, 32'd0,  32'd0,  32'd0, 7'b0000001};
        vecs[15] = '{1'b1, OP_IMM,    3'b001, 7'h20, 5'd1, 5'd2, 5'd5, 32'd10, 32'd3, 32'd4,  3'b000, 32'd0,  32'd0,  32'd0, 7'b0000001};
        vecs[16] = '{1'b1, OP_R,      3'b111, 7'h20, 5'd1, 5'd2, 5'd5, 32'd10, 32'd3, 32'd0,  3'b000, 32'd0,  32'd0,  32'd0, 7'b0000001};
        vecs[17] = '{1'b1, OP_LOAD,   3'b010, 7'h00, 5'd1, 5'd2, 5'd0, 32'd10, 32'd3, 32'd8,  3'b000, 32'd10, 32'd8,  32'd3, 7'b1010000};
        vecs[18] = '{1'b0, OP_R,      3'b000, 7'h20, 5'd1, 5'd2, 5'd5, 32'd10, 32'd3, 32'd0,  3'b000, 32'd0,  32'd0,  32'd0, 7'b0000000};
        vecs[19] = '{1'b1, OP_BRANCH, 3'b010, 7'h00, 5'd1, 5'd2, 5'd0, 32'd10, 32'd3, 32'd16, 3'b000, 32'd0,  32'd0,  32'd0, 7'b0000001};

        // Reset held two cycles with a valid instruction presented
        resetN = 1'b0; stall = 1'b0; flush = 1'b0; inPc = 32'h400;
        clear_fwd();
        set_instr(OP_R, 3'b000, 7'h20, 5'd1, 5'd2, 5'd5, 32'd10, 32'd3, 32'd0);
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst ctl", {25'd0, ctl()}, 32'd0);
            check("rst aluOp", {29'd0, aluOp}, 32'd0);
            check("rst op1", operand1, 32'd0);
            check("rst op2", operand2, 32'd0);
            check("rst hazard", {31'd0, hazardStall}, 32'd0);
        end
        resetN = 1'b1;
        tick();
        check("first cap valid", {31'd0, outValid}, 32'd1);
        check("first cap aluOp", {29'd0, aluOp}, 32'd1);
        check("first cap op1", operand1, 32'd10);

        for (int i = 0; i < 20; i++) begin
            set_instr(vecs[i].opc, vecs[i].f3, vecs[i].f7, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                      vecs[i].d1, vecs[i].d2, vecs[i].imm);
            inValid = vecs[i].v;
            inPc = 32'h1000 + 32'(i * 4);
            #1;
            check($sformatf("v%0d hazard", i), {31'd0, hazardStall}, 32'd0);
            tick();
            check($sformatf("v%0d aluOp", i), {29'd0, aluOp}, {29'd0, vecs[i].e_op});
            check($sformatf("v%0d op1", i), operand1, vecs[i].e_op1);
            check($sformatf("v%0d op2", i), operand2, vecs[i].e_op2);
            check($sformatf("v%0d store", i), outStoreData, vecs[i].e_sd);
            check($sformatf("v%0d ctl", i), {25'd0, ctl()}, {25'd0, vecs[i].e_ctl});
            check($sformatf("v%0d rd", i), {27'd0, outRd}, vecs[i].e_ctl[6] ? {27'd0, vecs[i].rd} : 32'd0);
            check($sformatf("v%0d pc", i), outPc, vecs[i].e_ctl[6] ? 32'h1000 + 32'(i * 4) : 32'd0);
        end

        // Forwarding priority EX/MEM over MEM/WB, and x0 never forwarded
        set_instr(OP_R, 3'b000, 7'h00, 5'd3, 5'd3, 5'd5, 32'd11, 32'd11, 32'd0);
        tick();
        inValid = 1'b0;
        exMemRegWrite = 1'b1; exMemRd = 5'd3; exMemResult = 32'd7;
        memWbRegWrite = 1'b1; memWbRd = 5'd3; memWbResult = 32'd9;
        #1;
`ifdef RV_FORWARDING_EN
        check("fwd ex op1", operand1, 32'd7);
        check("fwd ex op2", operand2, 32'd7);
        check("fwd ex store", outStoreData, 32'd7);
`else
        check("nofwd op1", operand1, 32'd11);
        check("nofwd store", outStoreData, 32'd11);
`endif
        exMemRegWrite = 1'b0;
        #1;
`ifdef RV_FORWARDING_EN
        check("fwd wb op1", operand1, 32'd9);
`else
        check("nofwd wb op1", operand1, 32'd11);
`endif
        memWbRegWrite = 1'b0;
        #1;
        check("fwd none op1", operand1, 32'd11);
        set_instr(OP_R, 3'b000, 7'h00, 5'd0, 5'd0, 5'd5, 32'd0, 32'd0, 32'd0);
        tick();
        inValid = 1'b0;
        exMemRegWrite = 1'b1; exMemRd = 5'd0; exMemResult = 32'd7;
        memWbRegWrite = 1'b1; memWbRd = 5'd0; memWbResult = 32'd9;
        #1;
        check("x0 op1", operand1, 32'd0);
        check("x0 op2", operand2, 32'd0);
        clear_fwd();

        // Load-use: one bubble, then the load result arrives via EX/MEM
        set_instr(OP_LOAD, 3'b010, 7'h00, 5'd1, 5'd0, 5'd4, 32'd10, 32'd0, 32'd0);
        tick();
        check("ld memRead", {31'd0, outMemRead}, 32'd1);
        set_instr(OP_R, 3'b000, 7'h00, 5'd4, 5'd1, 5'd6, 32'd50, 32'd10, 32'd0);
        #1;
        check("ld-use hazard", {31'd0, hazardStall}, 32'd1);
        tick();
        check("ld-use bubble", {31'd0, outValid}, 32'd0);
        exMemRegWrite = 1'b1; exMemRd = 5'd4; exMemResult = 32'd77;
        #1;
`ifdef RV_FORWARDING_EN
        check("ld-use released", {31'd0, hazardStall}, 32'd0);
`else
        check("exmem raw hazard", {31'd0, hazardStall}, 32'd1);
        tick();
        check("exmem raw bubble", {31'd0, outValid}, 32'd0);
        exMemRegWrite = 1'b0;
        memWbRegWrite = 1'b1; memWbRd = 5'd4; memWbResult = 32'd77;
        #1;
        check("memwb no hazard", {31'd0, hazardStall}, 32'd0);
`endif
        tick();
        check("ld-use cap valid", {31'd0, outValid}, 32'd1);
`ifdef RV_FORWARDING_EN
        check("ld-use fwd op1", operand1, 32'd77);
`else
        check("ld-use rf op1", operand1, 32'd50);
`endif
        check("ld-use op2", operand2, 32'd10);
        clear_fwd();

        // Flush on the load-use cycle suppresses the hazard and bubbles
        set_instr(OP_LOAD, 3'b010, 7'h00, 5'd1, 5'd0, 5'd4, 32'd10, 32'd0, 32'd0);
        tick();
        set_instr(OP_R, 3'b000, 7'h00, 5'd4, 5'd1, 5'd6, 32'd50, 32'd10, 32'd0);
        flush = 1'b1;
        #1;
        check("flush hazard", {31'd0, hazardStall}, 32'd0);
        tick();
        check("flush ctl", {25'd0, ctl()}, 32'd0);
        check("flush aluOp", {29'd0, aluOp}, 32'd0);
        flush = 1'b0;

        // ALU-producer RAW against this stage; flush beats stall
        set_instr(OP_R, 3'b000, 7'h00, 5'd1, 5'd2, 5'd5, 32'd10, 32'd3, 32'd0);
        tick();
        set_instr(OP_R, 3'b000, 7'h00, 5'd5, 5'd2, 5'd7, 32'd1, 32'd3, 32'd0);
        #1;
`ifdef RV_FORWARDING_EN
        check("alu raw hazard", {31'd0, hazardStall}, 32'd0);
`else
        check("alu raw hazard", {31'd0, hazardStall}, 32'd1);
`endif
        flush = 1'b1; stall = 1'b1;
        #1;
        check("flush+stall hazard", {31'd0, hazardStall}, 32'd0);
        tick();
        check("flush+stall valid", {31'd0, outValid}, 32'd0);
        flush = 1'b0; stall = 1'b0;

        // Stall held three cycles keeps every output constant
        set_instr(OP_R, 3'b000, 7'h20, 5'd1, 5'd2, 5'd5, 32'd10, 32'd3, 32'd0);
        tick();
        stall = 1'b1;
        set_instr(OP_R, 3'b000, 7'h01, 5'd3, 5'd3, 5'd6, 32'd99, 32'd99, 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("stall%0d ctl", c), {25'd0, ctl()}, 32'h60);
            check($sformatf("stall%0d aluOp", c), {29'd0, aluOp}, 32'd1);
            check($sformatf("stall%0d op1", c), operand1, 32'd10);
            check($sformatf("stall%0d op2", c), operand2, 32'd3);
            check($sformatf("stall%0d rd", c), {27'd0, outRd}, 32'd5);
        end
        stall = 1'b0;
        tick();
        check("post-stall aluOp", {29'd0, aluOp}, 32'd4);
        check("post-stall op1", operand1, 32'd99);

        // Reset mid-stall and mid-hazard
        stall = 1'b1; resetN = 1'b0;
        tick();
        check("rst stall valid", {31'd0, outValid}, 32'd0);
        check("rst stall op1", operand1, 32'd0);
        resetN = 1'b1; stall = 1'b0;
        set_instr(OP_LOAD, 3'b010, 7'h00, 5'd1, 5'd0, 5'd4, 32'd10, 32'd0, 32'd0);
        tick();
        set_instr(OP_R, 3'b000, 7'h00, 5'd4, 5'd1, 5'd6, 32'd50, 32'd10, 32'd0);
        #1;
        check("rst hz before", {31'd0, hazardStall}, 32'd1);
        resetN = 1'b0;
        tick();
        check("rst hz valid", {31'd0, outValid}, 32'd0);
        check("rst hz hazard", {31'd0, hazardStall}, 32'd0);
        resetN = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
